// File: rtl/pwm_width_capture.sv
// pwm_width_capture: recovers per-period high-time and period of an external PWM line in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-sample glitch filter ahead of the edge detector.
module pwm_width_capture #(
   parameter int WIDTH      = 32,
   parameter int TIMEOUT    = 100000,
   parameter int FILTER_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] width_out,
   output logic [WIDTH-1:0] period_out,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);
   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
   localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

   state_t           state;
   logic             sync1, s, p, lvl, rise, fall, tmo, report;
   logic [WIDTH-1:0] cnt, cnt_inc, high_len;

   if (TIMEOUT < 2 || FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_param
      $error("pwm_width_capture: TIMEOUT or FILTER_LEN out of range");
   end

`ifdef PWM_CAPTURE_FILTER_EN
   // p doubles as the filtered level; it flips once s has disagreed for FILTER_LEN samples
   localparam logic [7:0] FL = 8'(FILTER_LEN - 1);
   logic [7:0] fc;
   assign lvl = (s != p && fc == FL) ? s : p;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) fc <= '0;
      else fc <= (s == p || fc == FL) ? '0 : fc + 8'd1;
`else
   assign lvl = s;
`endif

   assign rise    = lvl & ~p;
   assign fall    = ~lvl & p;
   assign tmo     = cnt == TMO;
   assign cnt_inc = tmo ? cnt : cnt + WIDTH'(1);
   // edges beat a coincident timeout; ARM keeps re-reporting while the line stays stuck
   assign report  = enable && tmo && (state == HIGH ? !fall :
                                      state == LOW  ? !rise :
                                      state == ARM && stuck && !rise);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1       <= 1'b0;
         s           <= 1'b0;
         p           <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         high_len    <= '0;
         width_out   <= '0;
         period_out  <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         p     <= lvl;
         valid <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM:
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= WIDTH'(1);
                  end else if (stuck) cnt <= cnt_inc;
               HIGH: begin
                  cnt <= cnt_inc;
                  if (fall) begin
                     high_len <= cnt;
                     state    <= LOW;
                  end
               end
               LOW:
                  if (rise) begin
                     width_out  <= high_len;
                     period_out <= cnt;
                     valid      <= 1'b1;
                     stuck      <= 1'b0;
                     cnt        <= WIDTH'(1);
                     state      <= HIGH;
                  end else cnt <= cnt_inc;
               default: state <= IDLE;
            endcase
            if (report) begin
               width_out   <= '0;
               period_out  <= '0;
               stuck       <= 1'b1;
               stuck_level <= lvl;
               valid       <= 1'b1;
               cnt         <= WIDTH'(1);
               state       <= ARM;
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_width_capture.sv
// tb_pwm_width_capture: drives PWM periods and predicts every valid pulse (values and cycle) from period lengths.
module tb_pwm_width_capture;
   localparam int TMO = 300;
   localparam int FL  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT  = 3 + FL - 1;
   localparam int MINP = FL;
`else
   localparam int LAT  = 3;
   localparam int MINP = 1;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pwm_in = 1'b0;
   logic [31:0] width_out, period_out;
   logic        valid, stuck, stuck_level;
   int          cyc = 0, vectors = 0, miscompares = 0;

   typedef struct {logic [31:0] w; logic [31:0] p; logic st; logic lv; int due;} exp_t;
   typedef struct {int high; int low; int reps; logic [31:0] w; logic [31:0] p;} vec_t;

   exp_t q[$];
   bit   have_prev = 0, en = 0;
   int   prev_h = 0, prev_p = 0;
   logic last_lv = 1'b0;

   pwm_width_capture #(.WIDTH(32), .TIMEOUT(TMO), .FILTER_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_in(pwm_in),
      .width_out(width_out), .period_out(period_out), .valid(valid),
      .stuck(stuck), .stuck_level(stuck_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && valid) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid: cyc=%0d w=%0d p=%0d stuck=%0d", cyc, width_out, period_out, stuck);
         end else begin
            e = q.pop_front();
            if (width_out !== e.w || period_out !== e.p || stuck !== e.st || stuck_level !== e.lv || cyc != e.due) begin
               miscompares++;
               $display("FAIL valid_record: got w=%0d p=%0d st=%0d lv=%0d cyc=%0d, want w=%0d p=%0d st=%0d lv=%0d cyc=%0d",
                        width_out, period_out, stuck, stuck_level, cyc, e.w, e.p, e.st, e.lv, e.due);
            end
         end
      end
      if (q.size() != 0 && cyc > q[0].due) begin
         vectors++;
         miscompares++;
         $display("FAIL missing_valid: cyc=%0d, want w=%0d p=%0d st=%0d due at cyc %0d", cyc, q[0].w, q[0].p, q[0].st, q[0].due);
         q.delete(0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // One PWM period: h cycles high, l low; timeouts fire at every multiple of TMO before the next rise
   task automatic run_period(input int h, input int l, input int dis_at = 0, input int gl = 0);
      int c = cyc;
      int n = (h + l - 1) / TMO;
      if (have_prev) q.push_back('{prev_h, prev_p, 1'b0, last_lv, c + LAT});
      if (en)
         for (int i = 1; i <= n; i++) begin
            last_lv = (i * TMO < h);
            q.push_back('{32'd0, 32'd0, 1'b1, last_lv, c + LAT + i * TMO});
         end
      pwm_in = 1'b1;
      for (int i = 1; i <= h; i++) begin
         tick();
         if (i == dis_at) begin
            enable = 1'b0;
            en = 0;
         end
      end
      for (int i = 0; i < l; i++) begin
         pwm_in = (gl > 0 && i >= gl && i < gl + 2);
         tick();
      end
      pwm_in = 1'b0;
      have_prev = en && n == 0;
      prev_h = h;
      prev_p = h + l;
   endtask

   initial begin
      vec_t tbl[7];
      int   lo;
      tbl = '{'{3, 5, 4, 3, 8}, '{1, 255, 3, 1, 256}, '{10, 246, 3, 10, 256}, '{250, 6, 3, 250, 256},
              '{100, 200, 2, 100, 300}, '{4, 4, 3, 4, 8}, '{1, 1, 3, 1, 2}};
      repeat (3) tick();
      chk("reset_width", width_out, 0);
      chk("reset_period", period_out, 0);
      chk("reset_valid", {31'd0, valid}, 0);
      chk("reset_stuck", {31'd0, stuck}, 0);
      chk("reset_level", {31'd0, stuck_level}, 0);
      rst_n = 1'b1;
      enable = 1'b1;
      en = 1;
      repeat (2) tick();

      foreach (tbl[k]) begin
         if (tbl[k].high < MINP || tbl[k].low < MINP) continue;
         for (int r = 1; r <= tbl[k].reps; r++) begin
            lo = (r == tbl[k].reps && tbl[k].high + tbl[k].low < LAT) ? tbl[k].low + LAT : tbl[k].low;
            run_period(tbl[k].high, lo);
         end
         chk("tbl_width", width_out, tbl[k].w);
         chk("tbl_period", period_out, tbl[k].p);
         chk("tbl_stuck", {31'd0, stuck}, 0);
      end

      repeat (40) run_period(int'($urandom_range(20, MINP)), int'($urandom_range(20, MINP)));

      run_period(100, 201);
      repeat (LAT) tick();
      chk("tmo_plus1_stuck", {31'd0, stuck}, 1);
      chk("tmo_plus1_width", width_out, 0);
      repeat (3) run_period(4, 4);
      chk("recover_stuck", {31'd0, stuck}, 0);
      chk("recover_width", width_out, 4);

      run_period(700, 4);
      chk("stuck_high", {31'd0, stuck}, 1);
      chk("stuck_high_level", {31'd0, stuck_level}, 1);
      repeat (3) run_period(4, 4);
      chk("restore_period", period_out, 8);
      run_period(4, 700);
      chk("stuck_low_level", {31'd0, stuck_level}, 0);
      repeat (3) run_period(4, 4);
      chk("restore2_stuck", {31'd0, stuck}, 0);

      repeat (2) run_period(8, 8);
      run_period(8, 8, LAT + 1);
      repeat (2) run_period(8, 8);
      chk("hold_width", width_out, 8);
      chk("hold_period", period_out, 16);
      enable = 1'b1;
      en = 1;
      repeat (2) tick();
      repeat (3) run_period(6, 9);
      chk("reenable_width", width_out, 6);
      chk("reenable_period", period_out, 15);

`ifdef PWM_CAPTURE_FILTER_EN
      repeat (3) run_period(6, 10, 0, 3);
      run_period(6, 10);
      chk("glitch_width", width_out, 6);
      chk("glitch_period", period_out, 16);
`else
      repeat (2) begin
         run_period(6, 3);
         run_period(2, 5);
      end
      run_period(6, 10);
      chk("glitch_width", width_out, 2);
      chk("glitch_period", period_out, 7);
`endif

      run_period(5, 5);
      run_period(5, 3);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("midlow_rst_width", width_out, 0);
      chk("midlow_rst_period", period_out, 0);
      chk("midlow_rst_valid", {31'd0, valid}, 0);
      chk("midlow_rst_stuck", {31'd0, stuck}, 0);
      chk("midlow_rst_level", {31'd0, stuck_level}, 0);
      chk("midlow_rst_pending", q.size(), 0);
      have_prev = 0;
      last_lv = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      repeat (3) run_period(7, 5);
      chk("post_rst_width", width_out, 7);
      chk("post_rst_period", period_out, 12);
      run_period(3, 3);
      repeat (LAT + 2) tick();
      chk("drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
